// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_unit_pkg
// Purpose : Shared record type, FSM state encoding and helpers for the
//           branch resolve unit and its prediction FIFO.
// Revision: 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               pred_taken;
        logic [PC_W-1:0]    pred_target;
    } pred_rec_t;

    typedef enum logic [0:0] {
        BRU_NORMAL  = 1'b0,
        BRU_RECOVER = 1'b1
    } bru_state_e;

    // Architecturally correct fall-through/target PC; wraps at 2^64.
    function automatic logic [PC_W-1:0] bru_next_pc(
        input logic            taken,
        input logic [PC_W-1:0] pc,
        input logic [PC_W-1:0] target
    );
        return taken ? target : (pc + 64'd4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_pred_fifo.sv
`default_nettype none
// ============================================================================
// Module  : pred_fifo
// Purpose : In-order FIFO of prediction records with push, pop and a
//           synchronous clear that has priority over both.
// Revision: 1.0 - initial release
// ============================================================================
module pred_fifo
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  pred_rec_t push_rec,
    input  logic      pop,
    input  logic      clear,
    output pred_rec_t head,
    output logic      empty,
    output logic      full
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    pred_rec_t   mem_q [DEPTH];
    logic        wr_fire;
    logic        rd_fire;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_fire = push && !full && !clear;
    assign rd_fire = pop && !empty && !clear;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only observed between the pointers.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_unit
// Purpose : Matches execute outcomes against queued fetch predictions, drives
//           predictor updates and redirects. Optional counters: BRU_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_valid,
    output logic        push_ready,
    input  logic [63:0] push_pc,
    input  logic [31:0] push_instr,
    input  logic        push_pred_taken,
    input  logic [63:0] push_pred_target,
    input  logic        resolve_valid,
    input  logic [63:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic [63:0] resolve_target,
    output logic        update_en,
    output logic [63:0] update_pc,
    output logic [31:0] update_instr,
    output logic        actual_taken,
    output logic [63:0] actual_target,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        desync_err,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispredict
);

    bru_state_e  state_q, state_d;
    pred_rec_t   head;
    pred_rec_t   push_rec;
    logic        fifo_empty;
    logic        fifo_full;
    logic        match;
    logic        mispredict;
    logic        desync;
    logic        flush;
    logic        fifo_push;
    logic [63:0] next_pc;

    logic        update_en_q,      update_en_d;
    logic [63:0] update_pc_q,      update_pc_d;
    logic [31:0] update_instr_q,   update_instr_d;
    logic        actual_taken_q,   actual_taken_d;
    logic [63:0] actual_target_q,  actual_target_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [63:0] redirect_pc_q,    redirect_pc_d;
    logic        desync_err_q,     desync_err_d;

    assign push_rec = '{pc: push_pc, instr: push_instr,
                        pred_taken: push_pred_taken, pred_target: push_pred_target};

    always_comb begin
        push_ready = !fifo_full && (state_q == BRU_NORMAL);
        match      = resolve_valid && !fifo_empty && (head.pc == resolve_pc);
        mispredict = match && ((head.pred_taken != resolve_taken) ||
                               (resolve_taken && (head.pred_target != resolve_target)));
        desync     = resolve_valid && !match;
        flush      = mispredict || desync;
        // A push accepted alongside a flush is wrong-path; the handshake still completes.
        fifo_push  = push_valid && push_ready && !flush;
        next_pc    = bru_next_pc(resolve_taken, resolve_pc, resolve_target);
    end

    pred_fifo #(.DEPTH(DEPTH)) u_pred_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_rec (push_rec),
        .pop      (match),
        .clear    (flush),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_comb begin
        state_d          = flush ? BRU_RECOVER : BRU_NORMAL;
        update_en_d      = match;
        update_pc_d      = update_pc_q;
        update_instr_d   = update_instr_q;
        actual_taken_d   = actual_taken_q;
        actual_target_d  = actual_target_q;
        redirect_valid_d = flush;
        redirect_pc_d    = redirect_pc_q;
        desync_err_d     = desync;
        if (match) begin
            update_pc_d     = head.pc;
            update_instr_d  = head.instr;
            actual_taken_d  = resolve_taken;
            actual_target_d = resolve_target;
        end
        if (flush) redirect_pc_d = next_pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= BRU_NORMAL;
            update_en_q      <= 1'b0;
            update_pc_q      <= '0;
            update_instr_q   <= '0;
            actual_taken_q   <= 1'b0;
            actual_target_q  <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            desync_err_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            update_en_q      <= update_en_d;
            update_pc_q      <= update_pc_d;
            update_instr_q   <= update_instr_d;
            actual_taken_q   <= actual_taken_d;
            actual_target_q  <= actual_target_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            desync_err_q     <= desync_err_d;
        end
    end

    assign update_en      = update_en_q;
    assign update_pc      = update_pc_q;
    assign update_instr   = update_instr_q;
    assign actual_taken   = actual_taken_q;
    assign actual_target  = actual_target_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign desync_err     = desync_err_q;

`ifdef BRU_STATS_EN
    logic [31:0] stat_resolved_q,   stat_resolved_d;
    logic [31:0] stat_mispredict_q, stat_mispredict_d;

    always_comb begin
        stat_resolved_d   = stat_resolved_q   + {31'd0, match};
        stat_mispredict_d = stat_mispredict_q + {31'd0, mispredict};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_resolved_q   <= '0;
            stat_mispredict_q <= '0;
        end else begin
            stat_resolved_q   <= stat_resolved_d;
            stat_mispredict_q <= stat_mispredict_d;
        end
    end

    assign stat_resolved   = stat_resolved_q;
    assign stat_mispredict = stat_mispredict_q;
`else
    assign stat_resolved   = 32'd0;
    assign stat_mispredict = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_resolve_unit
// Purpose : Directed vector table plus hand-written fill/stats/reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid;
    logic        push_ready;
    logic [63:0] push_pc;
    logic [31:0] push_instr;
    logic        push_pred_taken;
    logic [63:0] push_pred_target;
    logic        resolve_valid;
    logic [63:0] resolve_pc;
    logic        resolve_taken;
    logic [63:0] resolve_target;
    logic        update_en;
    logic [63:0] update_pc;
    logic [31:0] update_instr;
    logic        actual_taken;
    logic [63:0] actual_target;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        desync_err;
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispredict;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .push_valid       (push_valid),
        .push_ready       (push_ready),
        .push_pc          (push_pc),
        .push_instr       (push_instr),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .resolve_valid    (resolve_valid),
        .resolve_pc       (resolve_pc),
        .resolve_taken    (resolve_taken),
        .resolve_target   (resolve_target),
        .update_en        (update_en),
        .update_pc        (update_pc),
        .update_instr     (update_instr),
        .actual_taken     (actual_taken),
        .actual_target    (actual_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .desync_err       (desync_err),
        .stat_resolved    (stat_resolved),
        .stat_mispredict  (stat_mispredict)
    );

    typedef struct {
        logic        pv;
        logic [63:0] ppc;
        logic        pt;
        logic [63:0] ptg;
        logic        rv;
        logic [63:0] rpc;
        logic        rt;
        logic [63:0] rtg;
        logic        e_upd;
        logic [63:0] e_upc;
        logic        e_at;
        logic [63:0] e_atg;
        logic        e_rdv;
        logic [63:0] e_rdpc;
        logic        e_des;
        logic        e_rdy;
    } vec_t;

    vec_t tv[$];

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hDEAD_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic pv, input logic [63:0] ppc, input logic pt, input logic [63:0] ptg,
                       input logic rv, input logic [63:0] rpc, input logic rt, input logic [63:0] rtg,
                       input logic e_upd, input logic [63:0] e_upc, input logic e_at, input logic [63:0] e_atg,
                       input logic e_rdv, input logic [63:0] e_rdpc, input logic e_des, input logic e_rdy);
        vec_t v;
        v = '{pv, ppc, pt, ptg, rv, rpc, rt, rtg, e_upd, e_upc, e_at, e_atg, e_rdv, e_rdpc, e_des, e_rdy};
        tv.push_back(v);
    endtask

    // Drive one cycle of inputs; returns #1 after the capturing edge.
    task automatic step(input logic pv, input logic [63:0] ppc, input logic pt, input logic [63:0] ptg,
                        input logic rv, input logic [63:0] rpc, input logic rt, input logic [63:0] rtg);
        push_valid       = pv;
        push_pc          = ppc;
        push_instr       = instr_of(ppc);
        push_pred_taken  = pt;
        push_pred_target = ptg;
        resolve_valid    = rv;
        resolve_pc       = rpc;
        resolve_taken    = rt;
        resolve_target   = rtg;
        @(posedge clk);
        #1;
        push_valid    = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".update_en"},      {63'd0, update_en},      64'd0);
        chk({tag, ".update_pc"},      update_pc,               64'd0);
        chk({tag, ".update_instr"},   {32'd0, update_instr},   64'd0);
        chk({tag, ".actual_taken"},   {63'd0, actual_taken},   64'd0);
        chk({tag, ".actual_target"},  actual_target,           64'd0);
        chk({tag, ".redirect_valid"}, {63'd0, redirect_valid}, 64'd0);
        chk({tag, ".redirect_pc"},    redirect_pc,             64'd0);
        chk({tag, ".desync_err"},     {63'd0, desync_err},     64'd0);
        chk({tag, ".push_ready"},     {63'd0, push_ready},     64'd1);
        chk({tag, ".stat_resolved"},  {32'd0, stat_resolved},  64'd0);
        chk({tag, ".stat_mispred"},   {32'd0, stat_mispredict}, 64'd0);
    endtask

    logic [31:0] exp_res;
    logic [31:0] exp_mis;

    initial begin
        reset = 1'b1;
        push_valid = 1'b0; push_pc = '0; push_instr = '0; push_pred_taken = 1'b0; push_pred_target = '0;
        resolve_valid = 1'b0; resolve_pc = '0; resolve_taken = 1'b0; resolve_target = '0;
        do_reset();
        chk_idle_outputs("reset");

        //  pv ppc          pt ptg          rv rpc          rt rtg            upd upc        at atg           rdv rdpc         des rdy
        // Correct not-taken prediction, then resolve against an empty queue
        add(1, 64'h100, 0, 64'h104,  0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        add(0, 64'h0,   0, 64'h0,    1, 64'h100, 0, 64'h0,    1, 64'h100, 0, 64'h0,    0, 64'h0,   0, 1);
        add(0, 64'h0,   0, 64'h0,    1, 64'h100, 0, 64'h0,    0, 64'h0,   0, 64'h0,    1, 64'h104, 1, 0);
        add(0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        // Taken with wrong target
        add(1, 64'h200, 1, 64'h300,  0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        add(0, 64'h0,   0, 64'h0,    1, 64'h200, 1, 64'h340,  1, 64'h200, 1, 64'h340,  1, 64'h340, 0, 0);
        add(0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        // Three in flight, oldest mispredicted; younger ones discarded
        add(1, 64'h10,  0, 64'h14,   0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        add(1, 64'h14,  0, 64'h18,   0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        add(1, 64'h18,  0, 64'h1c,   0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        add(0, 64'h0,   0, 64'h0,    1, 64'h10,  1, 64'h80,   1, 64'h10,  1, 64'h80,   1, 64'h80,  0, 0);
        add(0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        add(0, 64'h0,   0, 64'h0,    1, 64'h14,  0, 64'h0,    0, 64'h0,   0, 64'h0,    1, 64'h18,  1, 0);
        add(0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        // Resolve with empty queue
        add(0, 64'h0,   0, 64'h0,    1, 64'h500, 0, 64'h0,    0, 64'h0,   0, 64'h0,    1, 64'h504, 1, 0);
        add(0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        // Push in the same cycle as a mispredict is dropped
        add(1, 64'h600, 0, 64'h604,  0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        add(1, 64'h700, 0, 64'h704,  1, 64'h600, 1, 64'h900,  1, 64'h600, 1, 64'h900,  1, 64'h900, 0, 0);
        add(0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        add(0, 64'h0,   0, 64'h0,    1, 64'h700, 0, 64'h0,    0, 64'h0,   0, 64'h0,    1, 64'h704, 1, 0);
        add(0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        // Push alongside a correct match; correct taken prediction
        add(1, 64'hA00, 0, 64'hA04,  0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        add(1, 64'hA04, 1, 64'hB00,  1, 64'hA00, 0, 64'h0,    1, 64'hA00, 0, 64'h0,    0, 64'h0,   0, 1);
        add(0, 64'h0,   0, 64'h0,    1, 64'hA04, 1, 64'hB00,  1, 64'hA04, 1, 64'hB00,  0, 64'h0,   0, 1);
        add(0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        // Predicted taken, actually not taken
        add(1, 64'hC00, 1, 64'hD00,  0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        add(0, 64'h0,   0, 64'h0,    1, 64'hC00, 0, 64'hD00,  1, 64'hC00, 0, 64'hD00,  1, 64'hC04, 0, 0);
        add(0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        // PC mismatch with a non-empty queue flushes it
        add(1, 64'hE00, 0, 64'hE04,  0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        add(0, 64'h0,   0, 64'h0,    1, 64'hE08, 1, 64'hF00,  0, 64'h0,   0, 64'h0,    1, 64'hF00, 1, 0);
        add(0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        add(0, 64'h0,   0, 64'h0,    1, 64'hE00, 0, 64'h0,    0, 64'h0,   0, 64'h0,    1, 64'hE04, 1, 0);
        add(0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);
        // Fall-through PC wraps at 2^64
        add(0, 64'h0,   0, 64'h0,    1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 64'h0, 0, 64'h0, 1, 64'h0, 1, 0);
        add(0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 64'h0,    0, 64'h0,   0, 1);

        for (int i = 0; i < tv.size(); i++) begin
            string t;
            t = $sformatf("v%0d", i);
            step(tv[i].pv, tv[i].ppc, tv[i].pt, tv[i].ptg, tv[i].rv, tv[i].rpc, tv[i].rt, tv[i].rtg);
            chk({t, ".update_en"},      {63'd0, update_en},      {63'd0, tv[i].e_upd});
            chk({t, ".redirect_valid"}, {63'd0, redirect_valid}, {63'd0, tv[i].e_rdv});
            chk({t, ".desync_err"},     {63'd0, desync_err},     {63'd0, tv[i].e_des});
            chk({t, ".push_ready"},     {63'd0, push_ready},     {63'd0, tv[i].e_rdy});
            if (tv[i].e_upd) begin
                chk({t, ".update_pc"},     update_pc,             tv[i].e_upc);
                chk({t, ".update_instr"},  {32'd0, update_instr}, {32'd0, instr_of(tv[i].e_upc)});
                chk({t, ".actual_taken"},  {63'd0, actual_taken}, {63'd0, tv[i].e_at});
                chk({t, ".actual_target"}, actual_target,         tv[i].e_atg);
            end
            if (tv[i].e_rdv) chk({t, ".redirect_pc"}, redirect_pc, tv[i].e_rdpc);
        end

        // Fill to DEPTH, attempt an extra push, then drain in order
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 64'h1000 + 64'(4 * i), 1'b0, 64'h1004 + 64'(4 * i), 1'b0, 64'h0, 1'b0, 64'h0);
            chk($sformatf("fill%0d.push_ready", i), {63'd0, push_ready}, (i == 7) ? 64'd0 : 64'd1);
        end
        step(1'b1, 64'h2000, 1'b0, 64'h2004, 1'b0, 64'h0, 1'b0, 64'h0);
        chk("full.push_ready", {63'd0, push_ready}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h1000 + 64'(4 * i), 1'b0, 64'h0);
            chk($sformatf("drain%0d.update_en", i), {63'd0, update_en}, 64'd1);
            chk($sformatf("drain%0d.update_pc", i), update_pc, 64'h1000 + 64'(4 * i));
            chk($sformatf("drain%0d.redirect", i), {63'd0, redirect_valid}, 64'd0);
            chk($sformatf("drain%0d.push_ready", i), {63'd0, push_ready}, 64'd1);
        end
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h2000, 1'b0, 64'h0);
        chk("overfill.desync_err", {63'd0, desync_err}, 64'd1);
        chk("overfill.update_en", {63'd0, update_en}, 64'd0);
        idle();

        // Statistics: 5 resolves, 2 of them mispredicted
        do_reset();
`ifdef BRU_STATS_EN
        exp_res = 32'd5;
        exp_mis = 32'd2;
`else
        exp_res = 32'd0;
        exp_mis = 32'd0;
`endif
        step(1'b1, 64'h3000, 1'b0, 64'h3004, 1'b0, 64'h0, 1'b0, 64'h0);
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h3000, 1'b0, 64'h0);
        step(1'b1, 64'h3010, 1'b1, 64'h3100, 1'b0, 64'h0, 1'b0, 64'h0);
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h3010, 1'b1, 64'h3100);
        step(1'b1, 64'h3020, 1'b0, 64'h3024, 1'b0, 64'h0, 1'b0, 64'h0);
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h3020, 1'b1, 64'h3200);
        idle();
        step(1'b1, 64'h3030, 1'b1, 64'h3300, 1'b0, 64'h0, 1'b0, 64'h0);
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h3030, 1'b1, 64'h3340);
        idle();
        step(1'b1, 64'h3040, 1'b0, 64'h3044, 1'b0, 64'h0, 1'b0, 64'h0);
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h3040, 1'b0, 64'h0);
        chk("stats.update_en", {63'd0, update_en}, 64'd1);
        chk("stats.resolved", {32'd0, stat_resolved}, {32'd0, exp_res});
        chk("stats.mispredict", {32'd0, stat_mispredict}, {32'd0, exp_mis});

        // Asynchronous reset while an update pulse is showing
        step(1'b1, 64'h4000, 1'b0, 64'h4004, 1'b0, 64'h0, 1'b0, 64'h0);
        step(1'b1, 64'h4004, 1'b0, 64'h4008, 1'b0, 64'h0, 1'b0, 64'h0);
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h4000, 1'b0, 64'h0);
        chk("prerst.update_en", {63'd0, update_en}, 64'd1);
        reset = 1'b1;
        #1;
        chk_idle_outputs("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h4004, 1'b0, 64'h0);
        chk("postrst.desync_err", {63'd0, desync_err}, 64'd1);
        chk("postrst.redirect_pc", redirect_pc, 64'h4008);
        chk("postrst.update_en", {63'd0, update_en}, 64'd0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Closes the loop around the branch predictor. Fetch pushes each prediction it made (pc, instr, pred_taken, pred_target) into an in-order tracking queue. Execute reports the actual outcome. The block compares the two, drives the predictor's update port (update_en/update_pc/update_instr/actual_taken/actual_target), and issues a pipeline redirect/flush on mispredict.

Parameters:
DEPTH, 8, number of in-flight predictions tracked (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
push_valid  in  1  fetch offers a prediction record
push_ready  out  1  queue can accept a record
push_pc  in  64  PC of predicted instruction
push_instr  in  32  instruction word
push_pred_taken  in  1  predicted direction
push_pred_target  in  64  predicted next PC
resolve_valid  in  1  execute resolves one branch/jump this cycle
resolve_pc  in  64  PC of resolved instruction
resolve_taken  in  1  actual direction
resolve_target  in  64  actual target (meaningful when taken)
update_en  out  1  predictor update strobe
update_pc  out  64  PC to update
update_instr  out  32  instruction to update
actual_taken  out  1  actual direction
actual_target  out  64  actual target
redirect_valid  out  1  mispredict: flush younger, refetch
redirect_pc  out  64  correct next PC
desync_err  out  1  resolve had no matching head (pulse)
stat_resolved  out  32  resolved-branch count
stat_mispredict  out  32  mispredict count

Behaviour:
- Reset: queue empty, state NORMAL. All outputs 0 except push_ready=1. Stat counters are 0.
- Queue: FIFO of DEPTH records. Pointers are $clog2(DEPTH)+1 bits with wrap bit. full = pointers equal except MSB.
- push_ready = !full && state==NORMAL. Decode uses registered state only; no dependence on resolve_valid.
- Match: resolve_valid && !empty && head.pc==resolve_pc. Pops the head.
- Mispredict (on match): head.pred_taken != resolve_taken, or (resolve_taken && head.pred_target != resolve_target).
- Correct next PC: resolve_taken ? resolve_target : resolve_pc+4 (64-bit wrap).
- Outputs are registered, latency 1.
  - Cycle after a match: update_en=1, with update_pc/update_instr from the head and actual_* from resolve.
  - update_en is a single-cycle pulse; data outputs hold their last value otherwise.
- On mispredict:
  - Next cycle: redirect_valid=1 (single cycle), redirect_pc = correct next PC.
  - Queue is cleared (all younger entries are wrong-path).
  - state -> RECOVER.
- RECOVER: lasts exactly one cycle (push_ready=0), then NORMAL.
- Push and mispredict in the same cycle: the push handshake completes, but the record is dropped.
- Push and correct match in the same cycle: both occur. Count is unchanged. Legal even when full? No — push_ready=0 when full.
- resolve_valid with empty queue or PC mismatch:
  - No pop, no update.
  - desync_err=1 next cycle.
  - Queue flushed, redirect_valid=1 with redirect_pc = correct next PC, state -> RECOVER.
- Reset mid-operation: immediate clear of queue, state, and outputs. Any pending pulse is lost.

Optional Feature:
BRU_STATS_EN
- Defined: stat_resolved increments on every match, and stat_mispredict on every mispredict. Both are 32-bit, wrap at 2^32, and update in the same cycle as update_en.
- Undefined: both ports are constant 0 and no counter flops are inferred.

Decomposition:
- Shared package common: typedef struct packed pred_rec_t {pc[63:0], instr[31:0], pred_taken, pred_target[63:0]}; typedef enum {BRU_NORMAL, BRU_RECOVER}.
- Sub-module pred_fifo: DEPTH-parameterised pred_rec_t FIFO with push, pop, and clear, exposing head/empty/full.

Test Plan:
1. Push {pc=0x100, pred_taken=0, target=0x104}; resolve pc=0x100, taken=0 -> next cycle update_en=1, actual_taken=0, no redirect, queue empty.
2. Push {0x200, taken=1, target=0x300}; resolve taken=1, target=0x340 -> redirect_valid=1, redirect_pc=0x340, update actual_target=0x340. push_ready=0 for one cycle.
3. Push three records 0x10/0x14/0x18; first predicted not-taken, resolve 0x10 taken to 0x80 -> redirect_pc=0x80; later records discarded, empty afterward.
4. Fill DEPTH=8 records -> push_ready=0; one correct resolve -> push_ready=1 the following cycle.
5. Resolve pc=0x500 with empty queue -> desync_err=1, redirect_pc=0x504 (not taken), no update_en.
6. With BRU_STATS_EN: 5 resolves, 2 mispredicts -> stat_resolved=5, stat_mispredict=2. Assert reset mid-stream -> both 0.
